// File: rtl/cl_word_align.sv
// Camera Link word aligner: finds the clock-lane rotation, confirms it, then applies the same
// rotation to every data lane.
module cl_word_align #(
  parameter int unsigned NUM_LANES   = 4,
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned LOSS_CNT    = 4
) (
  input  logic                   RCLK,
  input  logic                   RST_N,
  input  logic [6:0]             CLK_WORD,
  input  logic [7*NUM_LANES-1:0] DATA_WORD,
  output logic [7*NUM_LANES-1:0] DATA_OUT,
  output logic [6:0]             CLK_OUT,
  output logic                   DATA_VALID,
  output logic [2:0]             OFFSET,
  output logic                   ALIGN_LOST
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  localparam logic [7:0] LockCntW = 8'(LOCK_CNT);
  localparam logic [7:0] LossCntW = 8'(LOSS_CNT);

  state_e                 state_q, state_d;
  logic [2:0]             offset_q, offset_d, offset_inc;
  logic [7:0]             match_cnt_q, match_cnt_d;
  logic [7:0]             miss_cnt_q, miss_cnt_d;
  logic [6:0]             clk_prev_q;
  logic [7*NUM_LANES-1:0] data_prev_q;
  logic [6:0]             clk_win;
  logic [7*NUM_LANES-1:0] data_win;
  logic                   match;
  logic                   lost_d;

  // Bit 0 is the earliest serial bit, so the previous word sits below the current one.
  function automatic logic [6:0] win_sel(input logic [6:0] cur, input logic [6:0] prev,
                                         input logic [2:0] off);
    logic [13:0] sh;
    sh = {cur, prev} >> off;
    return sh[6:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

  always_comb begin
    clk_win  = win_sel(CLK_WORD, clk_prev_q, offset_q);
    data_win = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      data_win[7*n +: 7] = win_sel(DATA_WORD[7*n +: 7], data_prev_q[7*n +: 7], offset_q);
    end
  end

  assign match      = (clk_win == CLK_PATTERN);
  assign offset_inc = (offset_q == 3'd6) ? 3'd0 : offset_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lost_d      = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (match) begin
          state_d     = StVerify;
          match_cnt_d = 8'd1;
        end else begin
          offset_d = offset_inc;
        end
      end
      StVerify: begin
        if (match) begin
          if (sat_inc(match_cnt_q) == LockCntW) begin
            state_d     = StLocked;
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = sat_inc(match_cnt_q);
          end
        end else begin
          state_d     = StSearch;
          match_cnt_d = 8'd0;
          offset_d    = offset_inc;
        end
      end
      StLocked: begin
        if (match) begin
          miss_cnt_d = 8'd0;
        end else if (sat_inc(miss_cnt_q) == LossCntW) begin
          state_d    = StSearch;
          miss_cnt_d = 8'd0;
          offset_d   = offset_inc;
          lost_d     = 1'b1;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge RCLK) begin
    if (!RST_N) begin
      state_q     <= StSearch;
      offset_q    <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      clk_prev_q  <= '0;
      data_prev_q <= '0;
      CLK_OUT     <= '0;
      DATA_OUT    <= '0;
      DATA_VALID  <= 1'b0;
      ALIGN_LOST  <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      clk_prev_q  <= CLK_WORD;
      data_prev_q <= DATA_WORD;
      CLK_OUT     <= clk_win;
      DATA_OUT    <= data_win;
      DATA_VALID  <= (state_d == StLocked);
      ALIGN_LOST  <= lost_d;
    end
  end

  assign OFFSET = offset_q;

endmodule
